serial_frame_deser: RTL and testbench

- Downstream consumer of the single-bit `d` → `q` flip-flop stage.
- Takes that registered serial bit stream, one bit per clock.
- Frames it as start bit + WIDTH data bits (LSB first) + stop bit, and presents each good word on a one-entry valid/ready output buffer.
- Flags framing errors and output overruns.

---
 rtl/serial_frame_pkg.sv | 12 +
 rtl/serial_frame_deser_if.sv | 31 +++
 rtl/serial_frame_outbuf.sv | 41 ++++
 rtl/serial_frame_deser.sv | 113 +++++++++++
 tb/tb_serial_frame_deser.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame deserializer: FSM state codes and line levels.
package serial_frame_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;
  localparam logic [1:0] ST_PAR  = 2'd3;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/serial_frame_deser_if.sv
// Output word handshake plus error pulses of the serial frame deserializer.
interface serial_frame_deser_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] q_data;
  logic             q_valid;
  logic             q_ready;
  logic             frame_err;
  logic             overrun;
  logic             par_err;

  modport master (
    output q_data,
    output q_valid,
    input  q_ready,
    output frame_err,
    output overrun,
    output par_err
  );

  modport slave (
    input  q_data,
    input  q_valid,
    output q_ready,
    input  frame_err,
    input  overrun,
    input  par_err
  );

endinterface

// File: rtl/serial_frame_outbuf.sv
// One-entry valid/ready holding register; a load into a full, unaccepted entry is dropped
// and reported as a one-cycle overrun pulse.
module serial_frame_outbuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  output logic             overrun
);

  logic xfer;

  assign xfer = q_valid && q_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_data  <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // An empty entry or one being drained this cycle can take the new word.
        if (!q_valid || xfer) begin
          q_data  <= ld_data;
          q_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: start bit, WIDTH data bits LSB first, optional even parity
// bit (SERIAL_FRAME_PARITY_CHECK_EN), stop bit; good words go to a one-entry output buffer.
module serial_frame_deser
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  serial_frame_deser_if.master q_if
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             load_req;
  logic             frame_err_r;

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
  logic             par_bit;
  logic             par_err_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      load_req    <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
      par_bit     <= 1'b0;
      par_err_r   <= 1'b0;
`endif
    end else begin
      load_req    <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
      par_err_r   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (d == START_LVL) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shreg   <= {d, shreg[WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
            state <= ST_PAR;
`else
            state <= ST_STOP;
`endif
          end
        end
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
        ST_PAR: begin
          par_bit <= d;
          state   <= ST_STOP;
        end
`endif
        ST_STOP: begin
          state <= ST_IDLE;
          // A bad stop bit wins over any parity result; the word is discarded either way.
          if (d == IDLE_LVL) begin
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
            if (((^shreg) ^ par_bit) != 1'b0) begin
              par_err_r <= 1'b1;
            end else begin
              load_req <= 1'b1;
            end
`else
            load_req <= 1'b1;
`endif
          end else begin
            frame_err_r <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // shreg is untouched between the stop edge and the load edge, so it feeds the buffer directly.
  serial_frame_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk     (clk),
    .rst     (rst),
    .load    (load_req),
    .ld_data (shreg),
    .q_ready (q_if.q_ready),
    .q_data  (q_if.q_data),
    .q_valid (q_if.q_valid),
    .overrun (q_if.overrun)
  );

  assign q_if.frame_err = frame_err_r;

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
  assign q_if.par_err = par_err_r;
`else
  assign q_if.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deser.sv
// Self-checking bench for serial_frame_deser (WIDTH=8): table-driven single frames plus
// hand-written back-to-back, overrun, coincident load/accept, reset and parity sequences.
module tb_serial_frame_deser;

  logic clk;
  logic rst;
  logic d;

  serial_frame_deser_if #(.WIDTH(8)) qif ();

  serial_frame_deser #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .q_if (qif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int fe_cnt  = 0;
  int ovr_cnt = 0;
  int par_cnt = 0;
  logic [7:0] xfer_q[$];

  // Mid-cycle monitor: a transfer happens on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (qif.q_valid && qif.q_ready) xfer_q.push_back(qif.q_data);
      if (qif.frame_err) fe_cnt++;
      if (qif.overrun)   ovr_cnt++;
      if (qif.par_err)   par_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    d = b;
    tick();
  endtask

  // Returns one time step after the stop-bit sampling edge.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    send_bit((^data) ^ par_flip);
`else
    if (par_flip) d = 1'b1;
`endif
    send_bit(stop);
    d = 1'b1;
  endtask

  task automatic chk_pop(input string name, input logic [7:0] exp);
    logic [7:0] v;
    if (xfer_q.size() == 0) begin
      chk({name, "_present"}, 32'd0, 32'd1);
    end else begin
      v = xfer_q.pop_front();
      chk(name, {24'd0, v}, {24'd0, exp});
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fe0, ovr0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_fe: 0};
    vecs[1] = '{data: 8'h5A, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_fe: 1};
    vecs[2] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_fe: 0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_fe: 0};
    vecs[4] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_fe: 0};

    rst = 1'b1;
    d = 1'b1;
    qif.q_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_q_valid",   {31'd0, qif.q_valid},   32'd0);
    chk("rst_q_data",    {24'd0, qif.q_data},    32'd0);
    chk("rst_frame_err", {31'd0, qif.frame_err}, 32'd0);
    chk("rst_overrun",   {31'd0, qif.overrun},   32'd0);
    chk("rst_par_err",   {31'd0, qif.par_err},   32'd0);

    for (int i = 0; i < 10; i++) send_bit(1'b1);
    chk("idle_q_valid", {31'd0, qif.q_valid}, 32'd0);

    // Table: one frame each with q_ready low, then drain the buffer.
    for (int i = 0; i < 5; i++) begin
      fe0 = fe_cnt;
      ovr0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      chk($sformatf("v%0d_valid_before_latency", i), {31'd0, qif.q_valid}, 32'd0);
      tick();
      chk($sformatf("v%0d_q_valid", i), {31'd0, qif.q_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        chk($sformatf("v%0d_q_data", i), {24'd0, qif.q_data}, {24'd0, vecs[i].exp_data});
      chk($sformatf("v%0d_frame_err_pulses", i), fe_cnt - fe0, vecs[i].exp_fe);
      chk($sformatf("v%0d_overrun_pulses", i), ovr_cnt - ovr0, 32'd0);
      qif.q_ready = 1'b1;
      tick();
      qif.q_ready = 1'b0;
      tick();
      chk($sformatf("v%0d_drained", i), {31'd0, qif.q_valid}, 32'd0);
      if (vecs[i].exp_valid) chk_pop($sformatf("v%0d_xfer", i), vecs[i].exp_data);
      chk($sformatf("v%0d_xfer_count", i), xfer_q.size(), 32'd0);
      xfer_q.delete();
    end

    // Back-to-back frames with the consumer always ready.
    ovr0 = ovr_cnt;
    qif.q_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick();
    tick();
    qif.q_ready = 1'b0;
    chk("b2b_xfer_count", xfer_q.size(), 32'd2);
    chk_pop("b2b_first", 8'h3C);
    chk_pop("b2b_second", 8'hC3);
    chk("b2b_overrun_pulses", ovr_cnt - ovr0, 32'd0);
    chk("b2b_q_valid", {31'd0, qif.q_valid}, 32'd0);
    xfer_q.delete();

    // Overrun: second word arrives while the first is still held.
    ovr0 = ovr_cnt;
    fe0 = fe_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    tick();
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_not_yet", {31'd0, qif.overrun}, 32'd0);
    tick();
    chk("ovr_pulse", {31'd0, qif.overrun}, 32'd1);
    chk("ovr_held_data", {24'd0, qif.q_data}, 32'h11);
    tick();
    chk("ovr_pulse_end", {31'd0, qif.overrun}, 32'd0);
    chk("ovr_held_data_later", {24'd0, qif.q_data}, 32'h11);
    chk("ovr_pulse_count", ovr_cnt - ovr0, 32'd1);
    chk("ovr_no_frame_err", fe_cnt - fe0, 32'd0);
    qif.q_ready = 1'b1;
    tick();
    qif.q_ready = 1'b0;
    chk("ovr_drained", {31'd0, qif.q_valid}, 32'd0);
    chk_pop("ovr_xfer", 8'h11);
    chk("ovr_xfer_count", xfer_q.size(), 32'd0);
    xfer_q.delete();

    // Coincident load and accept on the same edge.
    ovr0 = ovr_cnt;
    send_frame(8'h66, 1'b1, 1'b0);
    tick();
    chk("coin_held", {24'd0, qif.q_data}, 32'h66);
    send_frame(8'h77, 1'b1, 1'b0);
    qif.q_ready = 1'b1;
    tick();
    qif.q_ready = 1'b0;
    chk("coin_q_valid", {31'd0, qif.q_valid}, 32'd1);
    chk("coin_q_data", {24'd0, qif.q_data}, 32'h77);
    chk("coin_overrun", {31'd0, qif.overrun}, 32'd0);
    chk_pop("coin_xfer", 8'h66);
    tick();
    chk("coin_overrun_pulses", ovr_cnt - ovr0, 32'd0);
    qif.q_ready = 1'b1;
    tick();
    qif.q_ready = 1'b0;
    chk_pop("coin_xfer2", 8'h77);
    xfer_q.delete();

    // Reset in the middle of a frame; q_data still holds 0x77 before it.
    fe0 = fe_cnt;
    ovr0 = ovr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    d = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_q_data", {24'd0, qif.q_data}, 32'd0);
    chk("mid_rst_q_valid", {31'd0, qif.q_valid}, 32'd0);
    chk("mid_rst_frame_err", {31'd0, qif.frame_err}, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("mid_rst_no_fe", fe_cnt - fe0, 32'd0);
    chk("mid_rst_no_ovr", ovr_cnt - ovr0, 32'd0);
    chk("mid_rst_idle_valid", {31'd0, qif.q_valid}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    tick();
    chk("post_rst_q_valid", {31'd0, qif.q_valid}, 32'd1);
    chk("post_rst_q_data", {24'd0, qif.q_data}, 32'h81);
    qif.q_ready = 1'b1;
    tick();
    qif.q_ready = 1'b0;
    xfer_q.delete();

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    ovr0 = ovr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par_bad_pulse", {31'd0, qif.par_err}, 32'd1);
    tick();
    chk("par_bad_pulse_end", {31'd0, qif.par_err}, 32'd0);
    chk("par_bad_dropped", {31'd0, qif.q_valid}, 32'd0);
    chk("par_bad_count", par_cnt, 32'd1);
    send_frame(8'h07, 1'b1, 1'b0);
    tick();
    chk("par_good_q_valid", {31'd0, qif.q_valid}, 32'd1);
    chk("par_good_q_data", {24'd0, qif.q_data}, 32'h07);
    chk("par_good_count", par_cnt, 32'd1);
    chk("par_no_overrun", ovr_cnt - ovr0, 32'd0);
    fe0 = fe_cnt;
    qif.q_ready = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1);
    tick();
    qif.q_ready = 1'b0;
    chk("par_fe_priority_fe", fe_cnt - fe0, 32'd1);
    chk("par_fe_priority_par", par_cnt, 32'd1);
`else
    chk("par_err_never", par_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
